instruction_fetch_unit: RTL and testbench

//  Fetch stage directly upstream of the program ROM: owns the PC, drives the ROM byte address,

---
 rtl/instruction_fetch_unit.sv | 132 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage in front of the program ROM: owns the PC, drives the ROM byte address and
// captures the returned word into the IF/ID register, with stall, flush, redirects and fault lock.
module instruction_fetch_unit #(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    MEMORY_DEPTH = 1024,
   parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = 32'h0040_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall_i,
   input  logic                  flush_i,
   input  logic                  branch_taken_i,
   input  logic [DATA_WIDTH-1:0] branch_target_i,
   input  logic                  jump_i,
   input  logic [25:0]           jump_target_i,
   input  logic                  jr_i,
   input  logic [DATA_WIDTH-1:0] jr_target_i,
   input  logic [DATA_WIDTH-1:0] instruction_i,
   output logic [DATA_WIDTH-1:0] rom_address_o,
   output logic [DATA_WIDTH-1:0] pc_o,
   output logic [DATA_WIDTH-1:0] if_id_instruction_o,
   output logic [DATA_WIDTH-1:0] if_id_pc_plus4_o,
   output logic                  if_id_valid_o,
   output logic                  fetch_fault_o
);

   // First byte address past the ROM image; any PC at or above it is out of range.
   localparam logic [DATA_WIDTH-1:0] PC_LIMIT = TEXT_BASE + DATA_WIDTH'(4 * MEMORY_DEPTH);

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } state_t;

   state_t                state_q, state_n;
   logic [DATA_WIDTH-1:0] pc_q, pc_n;
   logic [DATA_WIDTH-1:0] instr_q, instr_n;
   logic [DATA_WIDTH-1:0] pc4_q, pc4_n;
   logic                  valid_q, valid_n;

   logic [DATA_WIDTH-1:0] pc_plus4;
   logic [DATA_WIDTH-1:0] candidate_pc;
   logic                  redirect;
   logic                  candidate_bad;

   // Candidate next PC, highest priority first; a redirect always beats a stall.
   always_comb begin
      pc_plus4     = pc_q + DATA_WIDTH'(4);
      redirect     = jr_i | jump_i | branch_taken_i;
      candidate_pc = pc_plus4;
      if (jr_i)
         candidate_pc = jr_target_i;
      else if (jump_i)
         candidate_pc = {if_id_pc_plus4_o[DATA_WIDTH-1:DATA_WIDTH-4], jump_target_i, 2'b00};
      else if (branch_taken_i)
         candidate_pc = branch_target_i;
      else if (stall_i)
         candidate_pc = pc_q;
      candidate_bad = (candidate_pc[1:0] != 2'b00) ||
                      (candidate_pc < TEXT_BASE)   ||
                      (candidate_pc >= PC_LIMIT);
   end

   // if_id_valid_o marks the IF/ID word as a real instruction; decode consumes it each
   // cycle unless it holds stall_i, which freezes the word in place.
   always_comb begin
      state_n = state_q;
      pc_n    = pc_q;
      instr_n = instr_q;
      pc4_n   = pc4_q;
      valid_n = valid_q;
      case (state_q)
         RUN: begin
            if (candidate_bad) begin
               state_n = FAULT;
               instr_n = '0;
               valid_n = 1'b0;
            end else if (redirect) begin
               // The word fetched this cycle belongs to the wrong path: one bubble.
               pc_n    = candidate_pc;
               instr_n = '0;
               valid_n = 1'b0;
            end else if (stall_i) begin
               pc_n    = pc_q;
            end else if (flush_i) begin
               pc_n    = candidate_pc;
               instr_n = '0;
               valid_n = 1'b0;
            end else begin
               pc_n    = candidate_pc;
               instr_n = instruction_i;
               pc4_n   = pc_plus4;
               valid_n = 1'b1;
            end
         end
         FAULT: begin
            instr_n = '0;
            valid_n = 1'b0;
         end
         default: begin
            state_n = FAULT;
            instr_n = '0;
            valid_n = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= RUN;
         pc_q    <= TEXT_BASE;
         instr_q <= '0;
         pc4_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_n;
         pc_q    <= pc_n;
         instr_q <= instr_n;
         pc4_q   <= pc4_n;
         valid_q <= valid_n;
      end
   end

   // The fault flag is the FSM state itself, so it doubles as the state debug view.
   assign fetch_fault_o       = (state_q == FAULT);
   assign rom_address_o       = pc_q - TEXT_BASE;
   assign pc_o                = pc_q;
   assign if_id_instruction_o = instr_q;
   assign if_id_pc_plus4_o    = pc4_q;
   assign if_id_valid_o       = valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Table-driven bench for instruction_fetch_unit: per-cycle vectors with hand-derived
// expectations, pushed to a scoreboard queue at drive time and popped after the clock edge.
module tb_instruction_fetch_unit;

   localparam logic [31:0] BASE = 32'h0040_0000;
   localparam int          EW   = 98;  // {pc, instr, pc_plus4, valid, fault}

   logic        clk;
   logic        reset;
   logic        stall_i, flush_i, branch_taken_i, jump_i, jr_i;
   logic [31:0] branch_target_i, jr_target_i, instruction_i;
   logic [25:0] jump_target_i;
   logic [31:0] rom_address_o, pc_o, if_id_instruction_o, if_id_pc_plus4_o;
   logic        if_id_valid_o, fetch_fault_o;

   int tests = 0;
   int fails = 0;

   logic [EW-1:0] exp_q[$];

   typedef struct {
      logic        rst;
      logic        stall;
      logic        flush;
      logic        br;
      logic [31:0] br_t;
      logic        jmp;
      logic [25:0] j_t;
      logic        jr;
      logic [31:0] jr_t;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic [31:0] e_pc4;
      logic        e_v;
      logic        e_f;
   } vec_t;

   vec_t vecs[$];

   instruction_fetch_unit dut (
      .clk                 (clk),
      .reset               (reset),
      .stall_i             (stall_i),
      .flush_i             (flush_i),
      .branch_taken_i      (branch_taken_i),
      .branch_target_i     (branch_target_i),
      .jump_i              (jump_i),
      .jump_target_i       (jump_target_i),
      .jr_i                (jr_i),
      .jr_target_i         (jr_target_i),
      .instruction_i       (instruction_i),
      .rom_address_o       (rom_address_o),
      .pc_o                (pc_o),
      .if_id_instruction_o (if_id_instruction_o),
      .if_id_pc_plus4_o    (if_id_pc_plus4_o),
      .if_id_valid_o       (if_id_valid_o),
      .fetch_fault_o       (fetch_fault_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ROM model: word n holds 0xA000_0000 + n.
   always_comb instruction_i = 32'hA000_0000 | {2'b00, rom_address_o[31:2]};

   function automatic logic [31:0] w(input int n);
      return 32'hA000_0000 + 32'(n);
   endfunction

   function automatic vec_t mk(input logic rst, input logic stall, input logic flush,
                               input logic br, input logic [31:0] br_t,
                               input logic jmp, input logic [25:0] j_t,
                               input logic jr, input logic [31:0] jr_t,
                               input logic [31:0] e_pc, input logic [31:0] e_instr,
                               input logic [31:0] e_pc4, input logic e_v, input logic e_f);
      vec_t v;
      v.rst = rst; v.stall = stall; v.flush = flush; v.br = br; v.br_t = br_t;
      v.jmp = jmp; v.j_t = j_t; v.jr = jr; v.jr_t = jr_t;
      v.e_pc = e_pc; v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_v = e_v; v.e_f = e_f;
      return v;
   endfunction

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_out();
      logic [EW-1:0] e;
      logic [31:0]   e_pc;
      if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL scoreboard: output sampled with empty expected queue");
         return;
      end
      e    = exp_q.pop_front();
      e_pc = e[97:66];
      chk("pc",       pc_o,                 e_pc);
      chk("rom_addr", rom_address_o,        e_pc - BASE);
      chk("if_instr", if_id_instruction_o,  e[65:34]);
      chk("if_pc4",   if_id_pc_plus4_o,     e[33:2]);
      chk("if_valid", {31'd0, if_id_valid_o}, {31'd0, e[1]});
      chk("fault",    {31'd0, fetch_fault_o}, {31'd0, e[0]});
   endtask

   // ---------------- driver ----------------
   task automatic apply(input vec_t v);
      @(negedge clk);
      reset           = ~v.rst;
      stall_i         = v.stall;
      flush_i         = v.flush;
      branch_taken_i  = v.br;
      branch_target_i = v.br_t;
      jump_i          = v.jmp;
      jump_target_i   = v.j_t;
      jr_i            = v.jr;
      jr_target_i     = v.jr_t;
      exp_q.push_back({v.e_pc, v.e_instr, v.e_pc4, v.e_v, v.e_f});
      @(posedge clk);
      #1;
      compare_out();
   endtask

   // Shorthands: reset, free-run, stall, flush, branch, jump, jr (with expected outputs).
   function automatic vec_t v_rst(input logic stall);
      return mk(1, stall, 0, 0, 0, 0, 0, 0, 0, BASE, 0, 0, 0, 0);
   endfunction
   function automatic vec_t v_run(input logic stall, input logic flush, input logic [31:0] pc,
                                  input logic [31:0] ins, input logic [31:0] p4,
                                  input logic vl, input logic f);
      return mk(0, stall, flush, 0, 0, 0, 0, 0, 0, pc, ins, p4, vl, f);
   endfunction

   initial begin
      reset = 1'b0; stall_i = 0; flush_i = 0; branch_taken_i = 0; jump_i = 0; jr_i = 0;
      branch_target_i = 0; jump_target_i = 0; jr_target_i = 0;

      // Reset and free run: IF/ID trails PC by one edge.
      vecs.push_back(v_rst(0));
      vecs.push_back(v_run(0, 0, 32'h0040_0004, w(0), 32'h0040_0004, 1, 0));
      vecs.push_back(v_run(0, 0, 32'h0040_0008, w(1), 32'h0040_0008, 1, 0));
      // Two stall cycles at 0x00400008 then resume.
      vecs.push_back(v_run(1, 0, 32'h0040_0008, w(1), 32'h0040_0008, 1, 0));
      vecs.push_back(v_run(1, 0, 32'h0040_0008, w(1), 32'h0040_0008, 1, 0));
      vecs.push_back(v_run(0, 0, 32'h0040_000C, w(2), 32'h0040_000C, 1, 0));
      vecs.push_back(v_run(0, 0, 32'h0040_0010, w(3), 32'h0040_0010, 1, 0));
      // Branch with stall: branch wins, one bubble, then word 0x10.
      vecs.push_back(mk(0, 1, 0, 1, 32'h0040_0040, 0, 0, 0, 0,
                        32'h0040_0040, 0, 32'h0040_0010, 0, 0));
      vecs.push_back(v_run(0, 0, 32'h0040_0044, w(16), 32'h0040_0044, 1, 0));
      // Jump builds {pc_plus4[31:28], index, 00}; jr outranks jump.
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 26'h010_0020, 0, 0,
                        32'h0040_0080, 0, 32'h0040_0044, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 26'h010_0020, 1, 32'h0040_0100,
                        32'h0040_0100, 0, 32'h0040_0044, 0, 0));
      vecs.push_back(v_run(0, 0, 32'h0040_0104, w(64), 32'h0040_0104, 1, 0));
      // Misaligned jr faults; later branch ignored; reset clears.
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h0040_0102,
                        32'h0040_0104, 0, 32'h0040_0104, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 32'h0040_0040, 0, 0, 0, 0,
                        32'h0040_0104, 0, 32'h0040_0104, 0, 1));
      vecs.push_back(v_run(0, 0, 32'h0040_0104, 0, 32'h0040_0104, 0, 1));
      vecs.push_back(v_rst(0));
      // jr to exactly the limit faults.
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h0040_1000, BASE, 0, 0, 0, 1));
      vecs.push_back(v_rst(0));
      // Flush without stall: PC advances, one bubble.
      vecs.push_back(v_run(0, 0, 32'h0040_0004, w(0), 32'h0040_0004, 1, 0));
      vecs.push_back(v_run(0, 1, 32'h0040_0008, 0,    32'h0040_0004, 0, 0));
      vecs.push_back(v_run(0, 0, 32'h0040_000C, w(2), 32'h0040_000C, 1, 0));
      // Flush is ignored while stalled.
      vecs.push_back(v_run(1, 1, 32'h0040_000C, w(2), 32'h0040_000C, 1, 0));
      // Branch below TEXT_BASE faults.
      vecs.push_back(mk(0, 0, 0, 1, 32'h003F_FFFC, 0, 0, 0, 0,
                        32'h0040_000C, 0, 32'h0040_000C, 0, 1));
      vecs.push_back(v_rst(0));
      // Last ROM word is reachable; sequential fetch past it faults.
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h0040_0FFC,
                        32'h0040_0FFC, 0, 0, 0, 0));
      vecs.push_back(v_run(0, 0, 32'h0040_0FFC, 0, 0, 0, 1));
      // Reset wins over a simultaneous stall.
      vecs.push_back(v_rst(1));

      for (int i = 0; i < vecs.size(); i++)
         apply(vecs[i]);

      // Hand sequence: stall of random length after reset, state must hold every cycle.
      begin
         int n;
         n = $urandom_range(2, 6);
         apply(v_rst(0));
         apply(v_run(0, 0, 32'h0040_0004, w(0), 32'h0040_0004, 1, 0));
         for (int k = 0; k < n; k++)
            apply(v_run(1, 0, 32'h0040_0004, w(0), 32'h0040_0004, 1, 0));
         apply(v_run(0, 0, 32'h0040_0008, w(1), 32'h0040_0008, 1, 0));
         // Redirect during stall on a later cycle, then resume at target.
         apply(mk(0, 1, 0, 0, 0, 0, 0, 1, 32'h0040_0020,
                  32'h0040_0020, 0, 32'h0040_0008, 0, 0));
         apply(v_run(0, 0, 32'h0040_0024, w(8), 32'h0040_0024, 1, 0));
      end

      if (exp_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
